up_sample_nearest_neighbor_controller: RTL
==========================================

// Module: up_sample_nearest_neighbor_controller
// PURPOSE
// - Loop-nest controller and compute stage for op_hcompute_nearest_neighbor_stencil.
// - Sits between hw_input_stencil_ub and nearest_neighbor_stencil_ub.
// - Walks the OUT_H x OUT_W output domain; reads the input buffer with output coordinates
//   (that buffer does the floor(/SCALE) itself), then writes the nearest_neighbor buffer.
// - Tracks input-row availability so no row is read before the upstream stage has written it.
// PARAMETERS
// - IN_W        64   input image width (pixels)
// - IN_H        64   input image height (rows)
// - SCALE_LOG2  1    log2 of up-sample factor; OUT_W = IN_W<<SCALE_LOG2, OUT_H = IN_H<<SCALE_LOG2
// - DATA_W      16   pixel width
// - CTRL_W      16   width of each ctrl_var
// - PIPE        1    read-to-write latency in cycles; must be >= 1
// PORTS
// - clk                                                  in   1           clock; all logic on rising edge
// - flush                                                in   1           synchronous active-high reset
// - start                                                in   1           1-cycle pulse; launches a frame when idle
// - stall                                                in   1           freezes the whole block while high
// - in_rows_avail                                        in   CTRL_W      count of fully written input rows
// - op_hcompute_nearest_neighbor_stencil_read_ren        out  1           read enable to hw_input_stencil_ub
// - op_hcompute_nearest_neighbor_stencil_read_ctrl_vars  out  3xCTRL_W    read coords {[0]=0, [1]=y, [2]=x}
// - op_hcompute_nearest_neighbor_stencil_read            in   DATA_W      read data; combinational, same cycle
// - op_hcompute_nearest_neighbor_stencil_write_wen       out  1           write enable to nearest_neighbor_stencil_ub
// - op_hcompute_nearest_neighbor_stencil_write_ctrl_vars out  3xCTRL_W    write coords {0, y, x}
// - op_hcompute_nearest_neighbor_stencil_write           out  DATA_W      write data
// - busy                                                 out  1           high from first RUN cycle until DONE exits
// - done                                                 out  1           1-cycle pulse at frame completion
// BEHAVIOUR
// - Reset (flush=1 at an edge): state IDLE; x=y=0; pipeline valids cleared.
//   All outputs 0, including ctrl_vars and write data.
// - FSM states and transitions:
//   - IDLE -> RUN when start=1.
//   - RUN -> DRAIN after the issue at (OUT_H-1, OUT_W-1).
//   - DRAIN -> DONE when all pipeline valids are 0.
//   - DONE -> IDLE unconditionally.
// - Issue rule (RUN, stall=0): issue when (y>>SCALE_LOG2) < in_rows_avail. An issue means:
//   - ren=1, ctrl_vars={0,y,x};
//   - read data and coords enter a PIPE-deep pipeline;
//   - x increments; at x==OUT_W-1, x wraps to 0 and y increments.
// - Dependency not met: ren=0, counters hold; the condition is re-evaluated every cycle (no extra state).
// - Write: wen=1 exactly PIPE unstalled cycles after the matching issue, with that issue's coords and data.
//   Throughput is 1 pixel/cycle.
// - stall=1: ren=0, wen=0; counters, pipeline and FSM hold; no pixel is duplicated or dropped.
//   ctrl_vars hold their last value.
// - done=1 only in the DONE state, for exactly one cycle. busy=0 in IDLE, 1 otherwise.
// - start ignored outside IDLE. start and flush together: flush wins.
// - flush mid-frame: next cycle equals reset. In-flight writes are discarded and no done is produced.
// - Arithmetic: counters are CTRL_W unsigned; OUT_W-1 and OUT_H-1 must fit in CTRL_W.
//   The comparison is unsigned.
// STRUCTURE
// - Shared package up_sample_pkg holds:
//   - DATA_W and CTRL_W localparams;
//   - typedef nn_state_e {IDLE, RUN, DRAIN, DONE};
//   - struct nn_coord_t {y, x}.
// - One sub-module: up_sample_nn_delay_pipe. It is a PIPE-deep valid/data/coord shift register
//   with a global enable (=~stall) and synchronous flush; its output drives wen/ctrl_vars/data.
// - The top module holds the FSM, the x/y counters and the dependency check.
// TESTING
// - Full frame, in_rows_avail=64, PIPE=1, input pixel(r,c)=r*64+c, start at cycle t:
//   - ren in cycles t+1..t+16384;
//   - 16384 wen with out(y,x)=(y>>1)*64+(x>>1);
//   - done exactly at t+16386.
// - in_rows_avail=0 after start: no ren for 20 cycles. Set it to 1: exactly 256 issues (rows 0,1),
//   then ren=0 with ctrl_vars y=2, x=0 held. Set it to 2: issues resume.
// - stall for 5 cycles at y=3, x=50: ren=wen=0 throughout. After release, the next write is (3,49)
//   and the next issue (3,50); no gaps or duplicates across the whole frame.
// - Wrap: issue at (5,127) is followed by (6,0); the final issue at (127,127) causes RUN->DRAIN;
//   busy drops the cycle after done.
// - flush at y=10 mid-frame: next cycle all outputs 0, no done. A subsequent start completes
//   a full, correct frame.
// - start pulsed while busy: ignored; counters continue unchanged; exactly one done.

Source files
------------

// File: rtl/up_sample_pkg.sv
// Shared types and widths for the nearest-neighbour up-sample stage.
//   DATA_W      pixel width
//   CTRL_W      width of one ctrl_var (coordinate)
//   nn_state_e  controller FSM states
//   nn_coord_t  output-domain coordinate {y, x}
package up_sample_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } nn_state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] y;
    logic [CTRL_W-1:0] x;
  } nn_coord_t;

endpackage

// File: rtl/up_sample_nn_delay_pipe.sv
// PIPE-deep valid/coord/data delay line between the read and write ports.
//   clk        clock, rising edge
//   flush      synchronous active-high clear of every stage
//   en         global advance enable (low freezes all stages)
//   in_valid   an issue enters stage 0 this cycle
//   in_coord   coordinate of the issue
//   in_data    read data of the issue
//   out_valid  last stage holds a pending write
//   out_coord  coordinate of the last stage (holds last written value)
//   out_data   data of the last stage (holds last written value)
//   in_flight  some stage other than the last holds a valid entry
module up_sample_nn_delay_pipe
  import up_sample_pkg::*;
#(
  parameter int unsigned PIPE = 1
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              en,
  input  logic              in_valid,
  input  nn_coord_t         in_coord,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output nn_coord_t         out_coord,
  output logic [DATA_W-1:0] out_data,
  output logic              in_flight
);

  logic [PIPE-1:0]   vld;
  nn_coord_t         crd [PIPE];
  logic [DATA_W-1:0] dat [PIPE];

  // Coord/data only move with a valid entry so the outputs keep the last
  // written values between writes.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld <= '0;
      for (int unsigned i = 0; i < PIPE; i++) begin
        crd[i] <= '0;
        dat[i] <= '0;
      end
    end else if (en) begin
      vld[0] <= in_valid;
      if (in_valid) begin
        crd[0] <= in_coord;
        dat[0] <= in_data;
      end
      for (int unsigned i = 1; i < PIPE; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          crd[i] <= crd[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  // The last stage is written out in the current cycle, so it does not
  // count as still in flight.
  always_comb begin
    in_flight = 1'b0;
    for (int unsigned i = 0; i + 1 < PIPE; i++) begin
      in_flight = in_flight | vld[i];
    end
  end

  assign out_valid = vld[PIPE-1];
  assign out_coord = crd[PIPE-1];
  assign out_data  = dat[PIPE-1];

endmodule

// File: rtl/up_sample_nearest_neighbor_controller.sv
// Loop-nest controller and compute stage for op_hcompute_nearest_neighbor_stencil.
// Walks the OUT_H x OUT_W output domain, reads hw_input_stencil_ub with output
// coordinates (the buffer applies the floor(/SCALE)) and writes the result to
// nearest_neighbor_stencil_ub PIPE cycles later. Rows are only read once the
// upstream stage reports them written via in_rows_avail.
//   clk, flush               clock; synchronous active-high reset
//   start                    launches a frame when idle
//   stall                    freezes the whole block
//   in_rows_avail            count of fully written input rows
//   *_read_ren/_ctrl_vars    read enable and {x, y, 0} read coordinates
//   *_read                   combinational read data
//   *_write_wen/_ctrl_vars   write enable and {x, y, 0} write coordinates
//   *_write                  write data
//   busy, done               frame in progress; one-cycle completion pulse
module up_sample_nearest_neighbor_controller
  import up_sample_pkg::*;
#(
  parameter int unsigned IN_W       = 64,
  parameter int unsigned IN_H       = 64,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned PIPE       = 1
) (
  input  logic                clk,
  input  logic                flush,
  input  logic                start,
  input  logic                stall,
  input  logic [CTRL_W-1:0]   in_rows_avail,
  output logic                op_hcompute_nearest_neighbor_stencil_read_ren,
  output logic [3*CTRL_W-1:0] op_hcompute_nearest_neighbor_stencil_read_ctrl_vars,
  input  logic [DATA_W-1:0]   op_hcompute_nearest_neighbor_stencil_read,
  output logic                op_hcompute_nearest_neighbor_stencil_write_wen,
  output logic [3*CTRL_W-1:0] op_hcompute_nearest_neighbor_stencil_write_ctrl_vars,
  output logic [DATA_W-1:0]   op_hcompute_nearest_neighbor_stencil_write,
  output logic                busy,
  output logic                done
);

  localparam int unsigned     OUT_W  = IN_W << SCALE_LOG2;
  localparam int unsigned     OUT_H  = IN_H << SCALE_LOG2;
  localparam logic [CTRL_W-1:0] X_LAST = CTRL_W'(OUT_W - 1);
  localparam logic [CTRL_W-1:0] Y_LAST = CTRL_W'(OUT_H - 1);

  nn_state_e         state;
  logic [CTRL_W-1:0] x;
  logic [CTRL_W-1:0] y;
  logic              dep_ok;
  logic              issue;
  logic              last_px;
  logic              in_flight;
  logic              pipe_valid;
  nn_coord_t         issue_coord;
  nn_coord_t         pipe_coord;
  logic [DATA_W-1:0] pipe_data;

  // Row y of the output maps to input row y>>SCALE_LOG2; it must be written.
  assign dep_ok  = (y >> SCALE_LOG2) < in_rows_avail;
  assign issue   = (state == RUN) && !stall && dep_ok;
  assign last_px = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else if (!stall) begin
      unique case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (issue) begin
            if (x == X_LAST) begin
              x <= '0;
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
            if (last_px) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!in_flight) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issue_coord = '{y: y, x: x};

  up_sample_nn_delay_pipe #(
    .PIPE (PIPE)
  ) u_delay_pipe (
    .clk       (clk),
    .flush     (flush),
    .en        (!stall),
    .in_valid  (issue),
    .in_coord  (issue_coord),
    .in_data   (op_hcompute_nearest_neighbor_stencil_read),
    .out_valid (pipe_valid),
    .out_coord (pipe_coord),
    .out_data  (pipe_data),
    .in_flight (in_flight)
  );

  assign op_hcompute_nearest_neighbor_stencil_read_ren       = issue;
  assign op_hcompute_nearest_neighbor_stencil_read_ctrl_vars = {x, y, {CTRL_W{1'b0}}};

  assign op_hcompute_nearest_neighbor_stencil_write_wen       = pipe_valid && !stall;
  assign op_hcompute_nearest_neighbor_stencil_write_ctrl_vars =
    {pipe_coord.x, pipe_coord.y, {CTRL_W{1'b0}}};
  assign op_hcompute_nearest_neighbor_stencil_write           = pipe_data;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
